// File: rtl/stream_dmux_1ton_if.sv
// Stream bundle for the 1-to-N demultiplexer: one producer-side stream, N consumer-side streams.
// The counter signals exist only when STREAM_DMUX_CNT_EN is defined.
interface stream_dmux_1ton_if #(
  parameter int WIDTH = 8,
  parameter int N_OUT = 4,
  parameter int CNT_W = 16
);
  localparam int SEL_W = $clog2(N_OUT);

  logic [WIDTH-1:0]       in_data;
  logic [SEL_W-1:0]       in_sel;
  logic                   in_valid;
  logic                   in_ready;
  logic [N_OUT*WIDTH-1:0] out_data;
  logic [N_OUT-1:0]       out_valid;
  logic [N_OUT-1:0]       out_ready;
  logic                   drop;
`ifdef STREAM_DMUX_CNT_EN
  logic                   cnt_clr;
  logic [N_OUT*CNT_W-1:0] out_count;
`endif

  modport master (
`ifdef STREAM_DMUX_CNT_EN
    output cnt_clr,
    input  out_count,
`endif
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_valid, drop
  );

  modport slave (
`ifdef STREAM_DMUX_CNT_EN
    input  cnt_clr,
    output out_count,
`endif
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_valid, drop
  );
endinterface

// File: rtl/stream_dmux_1ton.sv
// Registered 1-to-N stream demux with a one-word buffer and independent backpressure per channel.
// Optional per-channel delivery counters are enabled by defining STREAM_DMUX_CNT_EN.
module stream_dmux_1ton #(
  parameter int WIDTH = 8,
  parameter int N_OUT = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  stream_dmux_1ton_if.slave  bus
);
  localparam int SEL_W = $clog2(N_OUT);
  localparam logic [SEL_W:0] N_OUT_L = (SEL_W+1)'(N_OUT);

  logic [N_OUT-1:0]            valid_q, valid_d;
  logic [N_OUT-1:0][WIDTH-1:0] data_q, data_d;
  logic                        drop_q, drop_d;
  logic [SEL_W:0]              sel_ext;
  logic                        in_range;
  logic                        in_ready;
  logic                        accept;

  // Extra top bit lets an index >= N_OUT be compared without truncation.
  assign sel_ext  = {1'b0, bus.in_sel};
  assign in_range = (sel_ext < N_OUT_L);
  assign accept   = bus.in_valid & in_ready;

  // Out-of-range words are always accepted so they can be discarded.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    in_ready = 1'b1;
    for (int k = 0; k < N_OUT; k++) begin
      if (sel_ext == (SEL_W+1)'(k)) in_ready = !valid_q[k] | bus.out_ready[k];
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    drop_d  = accept & !in_range;
    for (int k = 0; k < N_OUT; k++) begin
      if (accept && sel_ext == (SEL_W+1)'(k)) begin
        valid_d[k] = 1'b1;
        data_d[k]  = bus.in_data;
      end else if (bus.out_ready[k]) begin
        valid_d[k] = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the data buffers are reset too, because out_data must read zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      data_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.drop      = drop_q;

`ifdef STREAM_DMUX_CNT_EN
  logic [N_OUT-1:0][CNT_W-1:0] cnt_q, cnt_d;

  // Saturating delivery counters; clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    for (int k = 0; k < N_OUT; k++) begin
      if (bus.cnt_clr) begin
        cnt_d[k] = '0;
      end else if (valid_q[k] && bus.out_ready[k] && cnt_q[k] != {CNT_W{1'b1}}) begin
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign bus.out_count = cnt_q;
`endif
endmodule

// File: tb/tb_stream_dmux_1ton.sv
// Bench for stream_dmux_1ton: a 4-channel and a 3-channel instance share one stimulus stream and
// are compared every cycle against a queue-based model of the routing rules.
module tb_stream_dmux_1ton;
  localparam int W  = 8;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stream_dmux_1ton_if #(.WIDTH(W), .N_OUT(4), .CNT_W(CW)) if4 ();
  stream_dmux_1ton_if #(.WIDTH(W), .N_OUT(3), .CNT_W(CW)) if3 ();

  stream_dmux_1ton #(.WIDTH(W), .N_OUT(4), .CNT_W(CW)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
  stream_dmux_1ton #(.WIDTH(W), .N_OUT(3), .CNT_W(CW)) dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

  // Both instances viewed through 4-channel-wide observation vectors (index 0: N=4, 1: N=3).
  logic [3:0]  o_valid [2];
  logic [31:0] o_data  [2];
  logic        o_rdy   [2];
  logic        o_drop  [2];
  assign o_valid[0] = if4.out_valid;
  assign o_valid[1] = {1'b0, if3.out_valid};
  assign o_data[0]  = if4.out_data;
  assign o_data[1]  = {8'h00, if3.out_data};
  assign o_rdy[0]   = if4.in_ready;
  assign o_rdy[1]   = if3.in_ready;
  assign o_drop[0]  = if4.drop;
  assign o_drop[1]  = if3.drop;
`ifdef STREAM_DMUX_CNT_EN
  logic [31:0] o_cnt [2];
  assign o_cnt[0] = if4.out_count;
  assign o_cnt[1] = {8'h00, if3.out_count};
`endif

  // Reference model: words waiting per channel, last word loaded, drop flag, delivery counts.
  logic [7:0] mq    [2][4][$];
  logic [7:0] mlast [2][4];
  logic       mdrop [2];
  int         mcnt  [2][4];
  bit         known = 1'b0;

  int compared   = 0;
  int mismatched = 0;

  function automatic int nch(input int d);
    return (d == 0) ? 4 : 3;
  endfunction

  function automatic logic exp_ready(input int d, input logic [1:0] s, input logic [3:0] r);
    if (int'(s) >= nch(d)) return 1'b1;
    return (mq[d][s].size() == 0) || r[s];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: drive, check in_ready, advance model, check registered outputs.
  task automatic cycle(input logic v, input logic [1:0] s, input logic [7:0] dt,
                       input logic [3:0] r, input logic rs, input logic clr);
    logic        acc [2];
    logic [3:0]  ev;
    logic [31:0] ed;
    @(negedge clk);
    rst          = rs;
    if4.in_valid = v;  if3.in_valid = v;
    if4.in_sel   = s;  if3.in_sel   = s;
    if4.in_data  = dt; if3.in_data  = dt;
    if4.out_ready = r; if3.out_ready = r[2:0];
`ifdef STREAM_DMUX_CNT_EN
    if4.cnt_clr = clr; if3.cnt_clr = clr;
`endif
    #1;
    for (int d = 0; d < 2; d++) begin
      acc[d] = v && exp_ready(d, s, r);
      if (known) check($sformatf("in_ready[%0d] sel=%0d", d, s), {31'b0, o_rdy[d]},
                       {31'b0, exp_ready(d, s, r)});
    end
    for (int d = 0; d < 2; d++) begin
      if (rs) begin
        for (int k = 0; k < 4; k++) begin
          mq[d][k].delete();
          mlast[d][k] = 8'h00;
          mcnt[d][k]  = 0;
        end
        mdrop[d] = 1'b0;
      end else begin
        for (int k = 0; k < nch(d); k++) begin
          logic deliver;
          deliver = (mq[d][k].size() != 0) && r[k];
          if (deliver) void'(mq[d][k].pop_front());
          if (clr) mcnt[d][k] = 0;
          else if (deliver && mcnt[d][k] < (2**CW - 1)) mcnt[d][k]++;
        end
        mdrop[d] = 1'b0;
        if (acc[d]) begin
          if (int'(s) < nch(d)) begin
            mq[d][s].push_back(dt);
            mlast[d][s] = dt;
          end else begin
            mdrop[d] = 1'b1;
          end
        end
      end
    end
    if (rs) known = 1'b1;
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      ev = '0;
      ed = '0;
      for (int k = 0; k < nch(d); k++) begin
        ev[k]         = (mq[d][k].size() != 0);
        ed[k*8 +: 8]  = mlast[d][k];
      end
      check($sformatf("out_valid[%0d]", d), {28'b0, o_valid[d]}, {28'b0, ev});
      check($sformatf("out_data[%0d]", d), o_data[d], ed);
      check($sformatf("drop[%0d]", d), {31'b0, o_drop[d]}, {31'b0, mdrop[d]});
`ifdef STREAM_DMUX_CNT_EN
      for (int k = 0; k < nch(d); k++)
        check($sformatf("out_count[%0d][%0d]", d, k), {24'b0, o_cnt[d][k*8 +: 8]}, 32'(mcnt[d][k]));
`endif
    end
  endtask

  initial begin
    logic       v, rs, clr;
    logic [1:0] s;
    logic [7:0] dt;
    logic [3:0] r;

    // Reset held for two cycles.
    cycle(1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 1'b0);
    cycle(1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 1'b0);
    check("reset out_valid", {28'b0, o_valid[0]}, 32'h0);
    check("reset out_data", o_data[0], 32'h0);
    check("reset in_ready", {31'b0, o_rdy[0]}, 32'h1);

    // Single routed word, then drained.
    cycle(1'b1, 2'd2, 8'hA5, 4'hF, 1'b0, 1'b0);
    check("route valid", {28'b0, o_valid[0]}, 32'h4);
    check("route data", {24'b0, o_data[0][23:16]}, 32'hA5);
    cycle(1'b0, 2'd0, 8'h00, 4'hF, 1'b0, 1'b0);
    check("route drained", {28'b0, o_valid[0]}, 32'h0);

    // Backpressure on channel 1: second word waits until the consumer is ready.
    cycle(1'b1, 2'd1, 8'h11, 4'b1101, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 2'd1, 8'h22, 4'b1101, 1'b0, 1'b0);
      check("bp held data", {24'b0, o_data[0][15:8]}, 32'h11);
      check("bp blocked", {31'b0, o_rdy[0]}, 32'h0);
    end
    cycle(1'b1, 2'd1, 8'h22, 4'hF, 1'b0, 1'b0);
    check("bp second word", {24'b0, o_data[0][15:8]}, 32'h22);
    cycle(1'b0, 2'd0, 8'h00, 4'hF, 1'b0, 1'b0);

    // Back-to-back words on channel 0.
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 2'd0, 8'(8'h30 + i), 4'hF, 1'b0, 1'b0);
      check("b2b valid", {31'b0, o_valid[0][0]}, 32'h1);
      check("b2b data", {24'b0, o_data[0][7:0]}, 32'(8'h30 + i));
    end
    cycle(1'b0, 2'd0, 8'h00, 4'hF, 1'b0, 1'b0);

    // Out-of-range select on the 3-channel instance.
    cycle(1'b1, 2'd3, 8'h77, 4'hF, 1'b0, 1'b0);
    check("oor drop", {31'b0, o_drop[1]}, 32'h1);
    check("oor no valid", {28'b0, o_valid[1]}, 32'h0);
    cycle(1'b0, 2'd0, 8'h00, 4'hF, 1'b0, 1'b0);
    check("oor drop one cycle", {31'b0, o_drop[1]}, 32'h0);

    // Reset while channel 3 holds a stalled word.
    cycle(1'b1, 2'd3, 8'h5A, 4'b0111, 1'b0, 1'b0);
    check("mid full", {31'b0, o_valid[0][3]}, 32'h1);
    cycle(1'b0, 2'd0, 8'h00, 4'b0111, 1'b1, 1'b0);
    check("mid reset", {31'b0, o_valid[0][3]}, 32'h0);
    cycle(1'b0, 2'd0, 8'h00, 4'hF, 1'b0, 1'b0);

`ifdef STREAM_DMUX_CNT_EN
    // Counter saturation and clear.
    for (int i = 0; i < 300; i++) cycle(1'b1, 2'd0, 8'(i), 4'hF, 1'b0, 1'b0);
    check("cnt saturate", {24'b0, o_cnt[0][7:0]}, 32'd255);
    cycle(1'b0, 2'd0, 8'h00, 4'hF, 1'b0, 1'b1);
    check("cnt clear", {24'b0, o_cnt[0][7:0]}, 32'd0);
`endif

    // Randomized traffic with occasional reset and counter clear.
    for (int i = 0; i < 800; i++) begin
      v   = ($urandom_range(3) != 0);
      s   = 2'($urandom);
      dt  = 8'($urandom);
      r   = 4'($urandom) | 4'($urandom);
      rs  = ($urandom_range(63) == 0);
      clr = ($urandom_range(39) == 0);
      cycle(v, s, dt, r, rs, clr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
